// File: rtl/sniff_pkg.sv
// Shared types and constants for the SPI sniffer frame packer.
package sniff_pkg;

    // Decoder events as they sit in the event queue
    typedef enum logic [1:0] {
        EV_START = 2'd0,
        EV_END   = 2'd1,
        EV_DATA  = 2'd2
    } ev_type_t;

    typedef struct packed {
        ev_type_t   ev;
        logic [7:0] mosi;
        logic [7:0] miso;
    } ev_entry_t;

    // Framing defaults
    localparam logic [7:0] SOF_DEFAULT     = 8'h7E;
    localparam logic [7:0] ESC_DEFAULT     = 8'h7D;
    localparam logic [7:0] ESC_XOR_DEFAULT = 8'h20;

    // Bit positions inside the trailer flags byte
    localparam int FLAG_DROP  = 0;
    localparam int FLAG_TRUNC = 1;
    localparam int FLAG_SAT   = 2;

    // Each state names the byte currently held in the output register
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_SOF,
        ST_HDR_SEQ,
        ST_D_MOSI,
        ST_D_MISO,
        ST_T_CNTH,
        ST_T_CNTL,
        ST_T_FLAGS,
        ST_T_EOF,
        ST_ESC2
    } fsm_state_t;

    // A byte between delimiters must be escaped if it looks like framing
    function automatic logic needs_esc(input logic [7:0] b,
                                       input logic [7:0] sof,
                                       input logic [7:0] esc);
        return (b == sof) || (b == esc);
    endfunction

endpackage

// File: rtl/sniff_frame_packer_if.sv
// Byte write port toward the UART TX FIFO.
interface sniff_frame_packer_if;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       fifo_full;

    modport master (output fifo_wr_en, output fifo_wr_data, input fifo_full);
    modport slave  (input fifo_wr_en, input fifo_wr_data, output fifo_full);
endinterface

// File: rtl/sniff_event_queue.sv
// Event queue: up to three pushes per cycle (DATA, END, START in that order),
// one pop per cycle. DATA keeps two entries in reserve for control events.
module sniff_event_queue
    import sniff_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input  logic                      clk_50m,
    input  logic                      rst,
    input  logic                      push_data,
    input  logic                      push_end,
    input  logic                      push_start,
    input  logic [7:0]                mosi_data,
    input  logic [7:0]                miso_data,
    input  logic                      pop,
    output ev_entry_t                 head,
    output logic [$clog2(QDEPTH):0]   free,
    output logic                      refused
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    ev_entry_t     mem [QDEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic          acc_data;
    logic          acc_end;
    logic          acc_start;
    logic [CW-1:0] free_after_data;
    logic [CW-1:0] free_after_end;
    logic [AW-1:0] slot_end;
    logic [AW-1:0] slot_start;
    logic [CW-1:0] n_push;
    logic          do_pop;

    // Admission: each accepted push consumes space before the next is judged
    always_comb begin
        free            = CW'(QDEPTH) - count_reg;
        acc_data        = push_data && (free >= CW'(3));
        free_after_data = free - CW'(acc_data);
        acc_end         = push_end && (free_after_data != '0);
        free_after_end  = free_after_data - CW'(acc_end);
        acc_start       = push_start && (free_after_end != '0);
        slot_end        = wr_ptr_reg + AW'(acc_data);
        slot_start      = slot_end + AW'(acc_end);
        n_push          = CW'(acc_data) + CW'(acc_end) + CW'(acc_start);
        do_pop          = pop && (count_reg != '0);
        refused         = (push_data && !acc_data) || (push_end && !acc_end) ||
                          (push_start && !acc_start);
    end

    // Pointers and occupancy
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(n_push);
            rd_ptr_reg <= rd_ptr_reg + AW'(do_pop);
            count_reg  <= count_reg + n_push - CW'(do_pop);
        end
    end

    // Entry storage; accepted pushes land in consecutive slots
    always_ff @(posedge clk_50m) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (acc_data && wr_ptr_reg == AW'(i))
                mem[i] <= '{ev: EV_DATA, mosi: mosi_data, miso: miso_data};
            else if (acc_end && slot_end == AW'(i))
                mem[i] <= '{ev: EV_END, mosi: 8'h00, miso: 8'h00};
            else if (acc_start && slot_start == AW'(i))
                mem[i] <= '{ev: EV_START, mosi: 8'h00, miso: 8'h00};
        end
    end

    assign head = mem[rd_ptr_reg];

endmodule

// File: rtl/sniff_frame_packer.sv
// Turns sniffer events into byte-stuffed frames, one byte per cycle into the
// UART TX FIFO. The output register always holds the byte named by state_reg.
module sniff_frame_packer
    import sniff_pkg::*;
#(
    parameter int         QDEPTH  = 8,
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter logic [7:0] ESC     = ESC_DEFAULT,
    parameter logic [7:0] ESC_XOR = ESC_XOR_DEFAULT
) (
    input  logic                        clk_50m,
    input  logic                        rst,
    input  logic                        cs_start,
    input  logic                        cs_end,
    input  logic                        data_valid,
    input  logic [7:0]                  mosi_data,
    input  logic [7:0]                  miso_data,
    sniff_frame_packer_if.master        fifo,
    output logic                        fifo_full_error
);
    localparam int QW = $clog2(QDEPTH) + 1;

    ev_entry_t   head;
    logic [QW-1:0] q_free;
    logic        q_empty;
    logic        refused;
    logic        pop;

    fsm_state_t  state_reg, state_next;
    fsm_state_t  saved_reg, saved_next;
    fsm_state_t  step;
    logic [7:0]  byte_reg, byte_next;
    logic [7:0]  esc_val_reg, esc_val_next;
    logic        esc_due_reg, esc_due_next;
    logic [7:0]  seq_reg, seq_next;
    logic [7:0]  miso_reg, miso_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        in_frame_reg, in_frame_next;
    logic        drop_reg, drop_next;
    logic        trunc_reg, trunc_next;
    logic        err_reg, err_next;

    logic        advance;
    logic        go_esc2;
    logic        fresh;
    logic        dispatch;
    logic        trunc_set;
    logic [7:0]  raw;
    logic        escapable;

    sniff_event_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .push_data  (data_valid),
        .push_end   (cs_end),
        .push_start (cs_start),
        .mosi_data  (mosi_data),
        .miso_data  (miso_data),
        .pop        (pop),
        .head       (head),
        .free       (q_free),
        .refused    (refused)
    );

    assign q_empty = (q_free == QW'(QDEPTH));

    // State and datapath registers
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            saved_reg    <= ST_IDLE;
            byte_reg     <= 8'h00;
            esc_val_reg  <= 8'h00;
            esc_due_reg  <= 1'b0;
            seq_reg      <= 8'h00;
            miso_reg     <= 8'h00;
            cnt_reg      <= 16'h0000;
            in_frame_reg <= 1'b0;
            drop_reg     <= 1'b0;
            trunc_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            saved_reg    <= saved_next;
            byte_reg     <= byte_next;
            esc_val_reg  <= esc_val_next;
            esc_due_reg  <= esc_due_next;
            seq_reg      <= seq_next;
            miso_reg     <= miso_next;
            cnt_reg      <= cnt_next;
            in_frame_reg <= in_frame_next;
            drop_reg     <= drop_next;
            trunc_reg    <= trunc_next;
            err_reg      <= err_next;
        end
    end

    // Next state: advance once the held byte is taken; frame-ending states
    // dispatch the queue head directly so back-to-back pairs see no bubble
    always_comb begin
        state_next = state_reg;
        saved_next = saved_reg;
        pop        = 1'b0;
        trunc_set  = 1'b0;
        go_esc2    = 1'b0;
        fresh      = 1'b0;
        dispatch   = 1'b0;
        advance    = (state_reg == ST_IDLE) || !fifo.fifo_full;
        step       = (state_reg == ST_ESC2) ? saved_reg : state_reg;
        if (advance) begin
            if (state_reg != ST_IDLE && esc_due_reg) begin
                go_esc2    = 1'b1;
                state_next = ST_ESC2;
                saved_next = state_reg;
            end else begin
                case (step)
                    ST_HDR_SOF: state_next = ST_HDR_SEQ;
                    ST_D_MOSI:  state_next = ST_D_MISO;
                    ST_T_CNTH:  state_next = ST_T_CNTL;
                    ST_T_CNTL:  state_next = ST_T_FLAGS;
                    ST_T_FLAGS: state_next = ST_T_EOF;
                    default:    dispatch   = 1'b1;
                endcase
                if (dispatch) begin
                    state_next = ST_IDLE;
                    if (!q_empty) begin
                        case (head.ev)
                            EV_START: begin
                                // A START inside a frame closes it first and
                                // stays queued until the trailer is out
                                if (in_frame_reg) begin
                                    state_next = ST_T_CNTH;
                                    trunc_set  = 1'b1;
                                end else begin
                                    state_next = ST_HDR_SOF;
                                    pop        = 1'b1;
                                end
                            end
                            EV_DATA: begin
                                pop = 1'b1;
                                if (in_frame_reg) state_next = ST_D_MOSI;
                            end
                            default: begin
                                pop = 1'b1;
                                if (in_frame_reg) state_next = ST_T_CNTH;
                            end
                        endcase
                    end
                end
                fresh = (state_next != ST_IDLE);
            end
        end
    end

    // Output byte and frame bookkeeping for the state being entered
    always_comb begin
        byte_next     = byte_reg;
        esc_val_next  = esc_val_reg;
        esc_due_next  = esc_due_reg;
        seq_next      = seq_reg;
        miso_next     = miso_reg;
        cnt_next      = cnt_reg;
        in_frame_next = in_frame_reg;
        drop_next     = drop_reg;
        trunc_next    = trunc_reg;
        raw           = 8'h00;
        escapable     = 1'b1;
        if (go_esc2) begin
            byte_next    = esc_val_reg;
            esc_due_next = 1'b0;
        end
        if (fresh) begin
            case (state_next)
                ST_HDR_SOF: begin
                    raw           = SOF;
                    escapable     = 1'b0;
                    in_frame_next = 1'b1;
                    cnt_next      = 16'h0000;
                    drop_next     = 1'b0;
                    trunc_next    = 1'b0;
                end
                ST_HDR_SEQ: begin
                    raw      = seq_reg;
                    seq_next = seq_reg + 8'd1;
                end
                ST_D_MOSI: begin
                    raw       = head.mosi;
                    miso_next = head.miso;
                    cnt_next  = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
                end
                ST_D_MISO: raw = miso_reg;
                ST_T_CNTH: begin
                    raw = cnt_reg[15:8];
                    if (trunc_set) trunc_next = 1'b1;
                end
                ST_T_CNTL: raw = cnt_reg[7:0];
                ST_T_FLAGS: begin
                    raw[FLAG_DROP]  = drop_reg;
                    raw[FLAG_TRUNC] = trunc_reg;
                    raw[FLAG_SAT]   = (cnt_reg == 16'hFFFF);
                end
                ST_T_EOF: begin
                    raw           = SOF;
                    escapable     = 1'b0;
                    in_frame_next = 1'b0;
                end
                default: raw = 8'h00;
            endcase
            if (escapable && needs_esc(raw, SOF, ESC)) begin
                byte_next    = ESC;
                esc_due_next = 1'b1;
                esc_val_next = raw ^ ESC_XOR;
            end else begin
                byte_next    = raw;
                esc_due_next = 1'b0;
            end
        end
        // A refused event marks the current frame even if a header clears it
        if (refused) drop_next = 1'b1;
        err_next = err_reg | refused;
    end

    // Write strobe is gated by full in the same cycle; the byte is registered
    assign fifo.fifo_wr_en   = (state_reg != ST_IDLE) && !fifo.fifo_full;
    assign fifo.fifo_wr_data = byte_reg;
    assign fifo_full_error   = err_reg;

endmodule
